mips_mc_ctrl: RTL and testbench

Multi-cycle main control FSM for the MIPS core. Consumes op (and the zero flag) from the instruction-decode/ALU path and sequences fetch, decode, execute, memory and writeback. It drives every datapath mux select and write enable, stalls on a memory ready handshake, and counts retired instructions.

---
 rtl/mips_pkg.sv | 84 ++++++++
 rtl/mips_mc_ctrl_if.sv | 51 +++++
 rtl/mips_mc_ctrl_outdec.sv | 75 +++++++
 rtl/mips_mc_ctrl.sv | 92 +++++++++
 tb/tb_mips_mc_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multi-cycle MIPS main controller.
//   - opcode constants (ins[31:26])
//   - 4-bit state enum; the numeric codes are visible on the debug state output
//   - encodings for alu_op, alu_src_b and pc_source
//   - ctrl_t: the full control word produced by the output decoder
//   - retires(): true on the cycles whose leaving edge retires an instruction
// Optional feature macro: MIPS_MC_CTRL_ILLEGAL_TRAP_EN adds the TRAP state and
// the trap bit of the control word.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_RWB     = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_ADDI_EX = 4'd11,
      S_ADDI_WB = 4'd12
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
      , S_TRAP  = 4'd13
`endif
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_t;

   typedef enum logic [1:0] {
      SRCB_B      = 2'b00,
      SRCB_FOUR   = 2'b01,
      SRCB_IMM    = 2'b10,
      SRCB_IMM_SH = 2'b11
   } srcb_t;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pcsrc_t;

   typedef struct packed {
      logic    pc_write;
      logic    pc_write_cond;
      logic    iord;
      logic    mem_read;
      logic    mem_write;
      logic    ir_write;
      logic    mem_to_reg;
      logic    reg_dst;
      logic    reg_write;
      logic    alu_src_a;
      srcb_t   alu_src_b;
      alu_op_t alu_op;
      pcsrc_t  pc_source;
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
      logic    trap;
`endif
   } ctrl_t;

   // A store retires only on the edge where memory accepts it.
   function automatic logic retires(state_t s, logic mem_ready);
      case (s)
         S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: return 1'b1;
         S_MEMWR: return mem_ready;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: bundle between the main controller and the datapath.
//   Inputs to controller : op, zero, mem_ready
//   Outputs of controller: datapath selects/enables, state (debug),
//                          instr_retired, trap (MIPS_MC_CTRL_ILLEGAL_TRAP_EN only)
// Memory handshake: mem_read/mem_write is the request and stays asserted,
// unchanged, on every cycle until mem_ready is sampled high at a rising clock
// edge; that edge completes the access and the request drops afterwards.
// modport master = controller, modport slave = datapath.
interface mips_mc_ctrl_if #(parameter int CNT_W = 32);
   logic [5:0]       op;
   logic             zero;
   logic             mem_ready;
   logic             pc_write;
   logic             pc_write_cond;
   logic             iord;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic             mem_to_reg;
   logic             reg_dst;
   logic             reg_write;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic [1:0]       pc_source;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_retired;
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
   logic             trap;
`endif

   modport master (
      input  op, zero, mem_ready,
      output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
      output mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
      output pc_source, state, instr_retired
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
      , output trap
`endif
   );

   modport slave (
      output op, zero, mem_ready,
      input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
      input  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
      input  pc_source, state, instr_retired
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
      , input trap
`endif
   );
endinterface

// File: rtl/mips_mc_ctrl_outdec.sv
// mips_mc_ctrl_outdec: pure combinational state -> control-word decoder.
//   state     : current FSM state
//   mem_ready : memory completion, qualifies ir_write/pc_write in FETCH
//   ctrl      : full control word; every field not set for a state is 0
// Optional feature macro: MIPS_MC_CTRL_ILLEGAL_TRAP_EN (TRAP drives trap only).
module mips_mc_ctrl_outdec
   import mips_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            // PC+4 is computed every fetch cycle but only committed, together
            // with the IR load, on the cycle memory returns the instruction.
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            // Speculative branch target into ALUOut.
            ctrl.alu_src_b = SRCB_IMM_SH;
         end
         S_MEMADR, S_ADDI_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_RWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         S_ADDI_WB: begin
            ctrl.reg_write = 1'b1;
         end
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
         S_TRAP: begin
            ctrl.trap = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS main control FSM.
//   clk   : clock
//   reset : asynchronous active-high reset (state=IDLE, instr_retired=0)
//   bus   : mips_mc_ctrl_if.master -- op/zero/mem_ready in, datapath
//           selects and enables, debug state and retired count out
// Parameter CNT_W: width of the retired-instruction counter (wraps).
// Optional feature macro: MIPS_MC_CTRL_ILLEGAL_TRAP_EN -- an unrecognised
// opcode parks the FSM in TRAP (trap=1) until reset; without it the opcode
// is a NOP that returns to FETCH without retiring.
// Outputs are decoded from the state register, so all enables are 0 for as
// long as reset is asserted.
module mips_mc_ctrl
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic           clk,
   input  logic           reset,
   mips_mc_ctrl_if.master bus
);

   state_t           state_q;
   logic [CNT_W-1:0] retired_q;
   ctrl_t            ctrl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
      end else begin
         if (retires(state_q, bus.mem_ready)) begin
            retired_q <= retired_q + CNT_W'(1);
         end
         case (state_q)
            S_IDLE:   state_q <= S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_q <= S_DECODE;
            S_DECODE: begin
               case (bus.op)
                  OP_RTYPE:     state_q <= S_EXEC;
                  OP_LW, OP_SW: state_q <= S_MEMADR;
                  OP_BEQ:       state_q <= S_BRANCH;
                  OP_J:         state_q <= S_JUMP;
                  OP_ADDI:      state_q <= S_ADDI_EX;
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
                  default:      state_q <= S_TRAP;
`else
                  default:      state_q <= S_FETCH;
`endif
               endcase
            end
            // Only lw/sw reach MEMADR, so anything but lw is a store.
            S_MEMADR:  state_q <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (bus.mem_ready) state_q <= S_MEMWB;
            S_MEMWR:   if (bus.mem_ready) state_q <= S_FETCH;
            S_EXEC:    state_q <= S_RWB;
            S_ADDI_EX: state_q <= S_ADDI_WB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: state_q <= S_FETCH;
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:    state_q <= S_TRAP;
`endif
            // Unused codes recover to FETCH.
            default:   state_q <= S_FETCH;
         endcase
      end
   end

   mips_mc_ctrl_outdec u_outdec (
      .state     (state_q),
      .mem_ready (bus.mem_ready),
      .ctrl      (ctrl)
   );

   assign bus.pc_write      = ctrl.pc_write;
   assign bus.pc_write_cond = ctrl.pc_write_cond;
   assign bus.iord          = ctrl.iord;
   assign bus.mem_read      = ctrl.mem_read;
   assign bus.mem_write     = ctrl.mem_write;
   assign bus.ir_write      = ctrl.ir_write;
   assign bus.mem_to_reg    = ctrl.mem_to_reg;
   assign bus.reg_dst       = ctrl.reg_dst;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.pc_source     = ctrl.pc_source;
   assign bus.state         = state_q;
   assign bus.instr_retired = retired_q;
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
   assign bus.trap          = ctrl.trap;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: bench for mips_mc_ctrl.
// The reference model works per instruction: when one starts, the opcode
// selects its list of visited state codes; FETCH/MEMRD/MEMWR repeat while
// mem_ready is low; finishing a legal instruction bumps the expected count.
// Each state code maps to its expected control word through a table.
module tb_mips_mc_ctrl;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   mips_mc_ctrl_if #(.CNT_W(32)) bus();

   mips_mc_ctrl #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
   localparam int NRAND = 6;
`else
   localparam int NRAND = 8;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [3:0]  exp_q[$];   // remaining state codes of the current instruction
   logic [6:0]  op_q[$];    // directed {zero, op} for upcoming instructions
   logic [3:0]  seen[$];
   logic [31:0] exp_ret;
   logic        cur_legal;
   int          mr_mode;
   int          wr_stall;
   int          n_wr;
   int          n_pwc;
   int          n_taken;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
   //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
   function automatic logic [15:0] dut_word();
      return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
              bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
              bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
              bus.pc_source};
   endfunction

   function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic mr);
      case (s)
         4'd1:    return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 2'b00};
         4'd2:    return {10'b0, 2'b11, 2'b00, 2'b00};
         4'd3:    return {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
         4'd4:    return {2'b00, 1'b1, 1'b1, 12'b0};
         4'd5:    return {6'b0, 1'b1, 1'b0, 1'b1, 7'b0};
         4'd6:    return {2'b00, 1'b1, 1'b0, 1'b1, 11'b0};
         4'd7:    return {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
         4'd8:    return {7'b0, 1'b1, 1'b1, 7'b0};
         4'd9:    return {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
         4'd10:   return {1'b1, 13'b0, 2'b10};
         4'd11:   return {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
         4'd12:   return {8'b0, 1'b1, 7'b0};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic build_path(input logic [5:0] o);
      cur_legal = 1'b1;
      case (o)
         6'h23:   exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
         6'h2B:   exp_q = '{4'd1, 4'd2, 4'd3, 4'd6};
         6'h00:   exp_q = '{4'd1, 4'd2, 4'd7, 4'd8};
         6'h08:   exp_q = '{4'd1, 4'd2, 4'd11, 4'd12};
         6'h04:   exp_q = '{4'd1, 4'd2, 4'd9};
         6'h02:   exp_q = '{4'd1, 4'd2, 4'd10};
         default: begin
            cur_legal = 1'b0;
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
            exp_q = '{4'd1, 4'd2, 4'd13};
`else
            exp_q = '{4'd1, 4'd2};
`endif
         end
      endcase
   endtask

   task automatic start_instr();
      logic [6:0] e;
      int k;
      if (op_q.size() != 0) begin
         e = op_q.pop_front();
      end else begin
         k = $urandom_range(0, NRAND - 1);
         case (k)
            0:       e[5:0] = 6'h00;
            1:       e[5:0] = 6'h23;
            2:       e[5:0] = 6'h2B;
            3:       e[5:0] = 6'h04;
            4:       e[5:0] = 6'h02;
            5:       e[5:0] = 6'h08;
            6:       e[5:0] = 6'h3F;
            default: e[5:0] = 6'($urandom_range(0, 63));
         endcase
         e[6] = 1'($urandom_range(0, 1));
      end
      bus.op   = e[5:0];
      bus.zero = e[6];
      build_path(e[5:0]);
   endtask

   task automatic advance(input logic [3:0] s, input logic mr);
      if (s == 4'd13) begin
         // TRAP holds until reset
      end else if ((s == 4'd1 || s == 4'd4 || s == 4'd6) && !mr) begin
         // wait state: same step again
      end else begin
         void'(exp_q.pop_front());
         if (exp_q.size() == 0 && cur_legal && s != 4'd0) exp_ret++;
      end
   endtask

   task automatic cycle();
      logic       mr;
      logic [3:0] s;
      @(negedge clk);
      if (exp_q.size() == 0) start_instr();
      s = exp_q[0];
      case (mr_mode)
         0: mr = 1'b1;
         1: begin
            mr = !(s == 4'd6 && wr_stall < 3);
            if (s == 4'd6 && !mr) wr_stall++;
         end
         2: mr = (s != 4'd4);
         default: mr = ($urandom_range(0, 9) < 7);
      endcase
      bus.mem_ready = mr;
      #1;
      chk("state", 32'(bus.state), 32'(s));
      chk("ctrl", 32'(dut_word()), 32'(exp_ctrl(s, mr)));
      chk("retired", bus.instr_retired, exp_ret);
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
      chk("trap", 32'(bus.trap), 32'(s == 4'd13));
`endif
      seen.push_back(bus.state);
      if (bus.mem_write) n_wr++;
      if (bus.pc_write_cond) n_pwc++;
      if (bus.pc_write_cond && bus.zero) n_taken++;
      advance(s, mr);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      exp_q   = '{4'd0};
      exp_ret = 32'd0;
   endtask

   // Assert reset between edges and check that it takes effect at once.
   task automatic reset_mid(input string nm);
      #2 reset = 1'b1;
      #1;
      chk({nm, "_state"}, 32'(bus.state), 32'd0);
      chk({nm, "_ctrl"}, 32'(dut_word()), 32'd0);
      chk({nm, "_retired"}, bus.instr_retired, 32'd0);
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
      chk({nm, "_trap"}, 32'(bus.trap), 32'd0);
`endif
      repeat (2) @(posedge clk);
      release_reset();
   endtask

   logic [3:0] lit_trace [24];

   initial begin
      bus.op        = 6'h00;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      exp_ret       = 32'd0;
      cur_legal     = 1'b0;
      mr_mode       = 0;
      wr_stall      = 0;
      n_wr          = 0;
      n_pwc         = 0;
      n_taken       = 0;
      lit_trace = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd7, 4'd8,
                    4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd3, 4'd6,
                    4'd6, 4'd6, 4'd6, 4'd1};

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_ctrl", 32'(dut_word()), 32'd0);
      chk("rst_retired", bus.instr_retired, 32'd0);
      release_reset();

      // lw, add, beq (zero=0), beq (zero=1), sw with 3 wait states
      op_q = '{{1'b0, 6'h23}, {1'b0, 6'h00}, {1'b0, 6'h04}, {1'b1, 6'h04},
               {1'b0, 6'h2B}};
      mr_mode = 1;
      seen.delete();
      repeat (24) cycle();
      for (int i = 0; i < 24; i++) chk("trace", 32'(seen[i]), 32'(lit_trace[i]));
      chk("dir_retired", bus.instr_retired, 32'd5);
      chk("sw_write_cycles", n_wr, 32'd4);
      chk("beq_cond_cycles", n_pwc, 32'd2);
      chk("beq_taken", n_taken, 32'd1);
      reset_mid("rst_fetch");

      // lw stalled in MEMRD, then reset mid-access
      op_q.push_back({1'b0, 6'h23});
      mr_mode = 2;
      repeat (6) cycle();
      chk("memrd_state", 32'(bus.state), 32'd4);
      chk("memrd_req", 32'({bus.mem_read, bus.iord}), 32'd3);
      reset_mid("rst_memrd");

      // Illegal opcode
      mr_mode = 0;
`ifdef MIPS_MC_CTRL_ILLEGAL_TRAP_EN
      op_q.push_back({1'b0, 6'h3F});
      repeat (14) cycle();
      chk("trap_state", 32'(bus.state), 32'd13);
      chk("trap_flag", 32'(bus.trap), 32'd1);
      chk("trap_retired", bus.instr_retired, 32'd0);
      reset_mid("rst_trap");
`else
      op_q.push_back({1'b0, 6'h3F});
      op_q.push_back({1'b0, 6'h00});
      repeat (4) cycle();
      chk("nop_state", 32'(bus.state), 32'd1);
      chk("nop_retired", bus.instr_retired, 32'd0);
`endif

      // Random instruction mix with random wait states
      mr_mode = 3;
      repeat (2000) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
